// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: LCG-driven vector source on a valid/ready handshake with a programmable vector budget
module lcg_stim_gen #(
  parameter int          VEC_W        = 141,
  parameter logic [31:0] SEED_DEFAULT = 32'hF30AC820,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             start,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [VEC_W-1:0] vec_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [31:0]      rng_state
);
  localparam int NWORDS = (VEC_W + 31) / 32;
  localparam int IW     = NWORDS > 1 ? $clog2(NWORDS) : 1;
  typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0]    word_idx;
  logic [CNT_W-1:0] budget, cnt_inc;
  logic [31:0]      n;
  logic [VEC_W-1:0] ins, msk;
  logic             idle_like, last, hs;
  assign n         = rng_state * 32'h41C64E6D + 32'h3039;
  assign idle_like = state == IDLE || state == DONE;
  assign last      = word_idx == IW'(NWORDS - 1);
  assign hs        = state == HOLD && vec_valid && vec_ready;
  assign cnt_inc   = vec_count + CNT_W'(1);
  assign busy      = state == FILL || state == HOLD;
  assign done      = state == DONE;
  // shifting past VEC_W drops the excess, which truncates the final word for free
  assign ins       = VEC_W'(n) << {word_idx, 5'd0};
  assign msk       = VEC_W'(32'hFFFF_FFFF) << {word_idx, 5'd0};
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? (num_vectors == '0 ? DONE : FILL) : state;
      FILL:       state_n = last ? HOLD : FILL;
      HOLD:       state_n = hs ? (cnt_inc == budget ? DONE : FILL) : HOLD;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng_state <= SEED_DEFAULT;
      vec_data  <= '0;
      vec_valid <= 1'b0;
      vec_count <= '0;
      word_idx  <= '0;
      budget    <= '0;
    end else if (idle_like) begin
      if (seed_load) rng_state <= seed_in;
      if (start) begin
        budget    <= num_vectors;
        vec_count <= '0;
        vec_valid <= 1'b0;
        word_idx  <= '0;
      end
    end else if (state == FILL) begin
      rng_state <= n;
      vec_data  <= (vec_data & ~msk) | (ins & msk);
      word_idx  <= last ? '0 : word_idx + IW'(1);
      if (last) vec_valid <= 1'b1;
    end else if (hs) begin
      vec_count <= cnt_inc;
      vec_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: scoreboard bench comparing emitted vectors against a software LCG
module tb_lcg_stim_gen;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         seed_load = 1'b0;
  logic [31:0]  seed_in = '0;
  logic [31:0]  num_vectors = '0;
  logic         start = 1'b0;
  logic         vec_valid;
  logic         vec_ready = 1'b0;
  logic [140:0] vec_data;
  logic         busy, done;
  logic [31:0]  vec_count, rng_state;
  int           errors = 0;
  int           checks = 0;
  logic [31:0]  ms;
  logic [31:0]  rng1;
  logic [159:0] q[$];
  lcg_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .num_vectors(num_vectors), .start(start), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_data(vec_data), .busy(busy), .done(done),
    .vec_count(vec_count), .rng_state(rng_state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push_vec();
    logic [159:0] v;
    v = '0;
    for (int w = 0; w < 5; w++) begin
      ms = ms * 32'h41C64E6D + 32'h3039;
      v[32*w +: 32] = ms;
    end
    v[159:141] = '0;
    q.push_back(v);
  endtask
  task automatic do_start(input logic [31:0] nv, input logic sl, input logic [31:0] sd);
    @(posedge clk); #1;
    start = 1'b1; num_vectors = nv; seed_load = sl; seed_in = sd;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !done; i++) @(negedge clk);
    check("done_timeout", 160'(done), 1);
  endtask
  task automatic wait_valid(input int lim);
    for (int i = 0; i < lim && !vec_valid; i++) @(negedge clk);
    check("valid_timeout", 160'(vec_valid), 1);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_rng"}, 160'(rng_state), 160'(32'hF30AC820));
    check({tag, "_valid"}, 160'(vec_valid), 0);
    check({tag, "_busy"}, 160'(busy), 0);
    check({tag, "_done"}, 160'(done), 0);
    check({tag, "_cnt"}, 160'(vec_count), 0);
    check({tag, "_data"}, {19'b0, vec_data}, 0);
  endtask
  always @(negedge clk)
    if (vec_valid && vec_ready) begin
      if (q.size() == 0) check("extra_vec", {19'b0, vec_data}, 0);
      else check("vec", {19'b0, vec_data}, q.pop_front());
    end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_reset("rst");
    vec_ready = 1'b1;
    ms = 32'h0;
    push_vec();
    do_start(1, 1'b1, 32'h0);
    check("t1_busy", 160'(busy), 1);
    repeat (4) @(posedge clk);
    #1 check("t1_early", 160'(vec_valid), 0);
    @(posedge clk);
    #1 check("t1_valid", 160'(vec_valid), 1);
    check("t1_w0", 160'(vec_data[31:0]), 160'(32'h00003039));
    check("t1_w1", 160'(vec_data[63:32]), 160'(32'hD3DC167E));
    wait_done(20);
    check("t1_cnt", 160'(vec_count), 1);
    check("t1_busy_end", 160'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    ms = 32'hF30AC820;
    for (int i = 0; i < 201; i++) push_vec();
    do_start(201, 1'b0, 32'h0);
    wait_done(201 * 6 + 20);
    check("t2_cnt", 160'(vec_count), 201);
    check("t2_q", 160'(q.size()), 0);
    vec_ready = 1'b0;
    push_vec();
    rng1 = ms;
    push_vec();
    do_start(2, 1'b0, 32'h0);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 160'(vec_valid), 1);
      check("hold_data", {19'b0, vec_data}, q[0]);
      check("hold_rng", 160'(rng_state), 160'(rng1));
      check("hold_cnt", 160'(vec_count), 0);
    end
    @(posedge clk); #1 vec_ready = 1'b1;
    @(posedge clk); #1 check("hold_cnt1", 160'(vec_count), 1);
    wait_done(30);
    check("t3_cnt", 160'(vec_count), 2);
    do_start(0, 1'b0, 32'h0);
    check("z_done", 160'(done), 1);
    check("z_busy", 160'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("z_valid", 160'(vec_valid), 0);
    end
    check("z_rng", 160'(rng_state), 160'(ms));
    check("z_cnt", 160'(vec_count), 0);
    push_vec();
    do_start(1, 1'b0, 32'h0);
    @(posedge clk); #1;
    start = 1'b1; seed_load = 1'b1; seed_in = $urandom; num_vectors = 5;
    repeat (2) @(posedge clk);
    #1 start = 1'b0; seed_load = 1'b0;
    wait_done(30);
    check("dist_cnt", 160'(vec_count), 1);
    check("dist_rng", 160'(rng_state), 160'(ms));
    do_start(3, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    ms = 32'hF30AC820;
    push_vec();
    push_vec();
    do_start(2, 1'b0, 32'h0);
    wait_done(40);
    check("rerun_cnt", 160'(vec_count), 2);
    check("sb_empty", 160'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcg_stim_gen.md
Name: lcg_stim_gen

Overview:
- Synthesizable upstream stimulus source for the fuzzed `top` DUT. Produces the 141-bit `in_flat` vectors with the team's deterministic cross-simulator LCG: state' = state*32'h41C64E6D + 32'h3039 (mod 2^32).
- Vectors are filled 32 bits at a time, low word first. The final word is truncated.
- Vectors are presented on a valid/ready handshake. A programmable vector budget ends the run.

Parameters:
- VEC_W, 141, output vector width. Must be at least 1.
- NWORDS, ceil(VEC_W/32) = 5, number of LCG steps per vector. Derived, not overridable.
- SEED_DEFAULT, 32'hF30AC820 (4077570080), LCG state after reset.
- CNT_W, 32, width of the vector budget and counter.

Ports:
- clk  in  1  clock. All logic is posedge.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  loads seed_in into the LCG state. Honoured only in IDLE or DONE.
- seed_in  in  32  seed value.
- num_vectors  in  CNT_W  vector budget. Sampled when start is accepted.
- start  in  1  begins a run. Honoured only in IDLE or DONE.
- vec_valid  out  1  vec_data holds a complete vector.
- vec_ready  in  1  consumer accepts the vector.
- vec_data  out  VEC_W  generated vector (drives DUT in_flat).
- busy  out  1  high in FILL or HOLD.
- done  out  1  high in DONE.
- vec_count  out  CNT_W  vectors accepted in the current run.
- rng_state  out  32  current LCG state.

Behaviour:
- Reset (async, any state): state=IDLE, rng_state=SEED_DEFAULT, vec_data=0, vec_valid=0, busy=0, done=0, vec_count=0, word_idx=0, budget=0.
- FSM states: IDLE, FILL, HOLD, DONE.
- IDLE/DONE:
  - seed_load=1 → rng_state<=seed_in.
  - start=1 → budget<=num_vectors, vec_count<=0, vec_valid<=0.
  - If num_vectors==0, go to DONE; otherwise go to FILL with word_idx=0.
  - seed_load and start in the same cycle: the seed is loaded, and the first step of the run uses seed_in.
  - start without seed_load continues from the current rng_state. There is no implicit reseed.
- FILL: each cycle computes n = rng_state*32'h41C64E6D + 32'h3039 and sets rng_state<=n.
  - Writes vec_data[32*word_idx +: 32]<=n.
  - For the last word, writes only bits [VEC_W-1:32*(NWORDS-1)] from n[VEC_W-32*(NWORDS-1)-1:0], i.e. [140:128]<=n[12:0].
  - word_idx increments. After word NWORDS-1: vec_valid<=1, go to HOLD.
- HOLD:
  - vec_data and vec_valid are held stable until vec_valid&&vec_ready.
  - On handshake: vec_count++ and vec_valid<=0. If vec_count+1==budget, go to DONE; else go to FILL with word_idx=0.
  - The 32-bit LCG math wraps modulo 2^32. vec_count wraps naturally but cannot exceed budget.
- Timing:
  - With start accepted at edge E0, the words are written at E1..E5 and vec_valid is high after E5.
  - With ready tied high, throughput is 1 vector per 6 cycles and the handshake occurs at E6.
- vec_ready while vec_valid=0 is ignored. No combinational path from vec_ready to vec_valid or vec_data.
- The previous vector's bits remain in vec_data during FILL. Consumers must use the vector only while vec_valid=1.
- start or seed_load while busy is ignored and the run is undisturbed.
- done stays high until the next accepted start or reset.
- Reset mid-FILL or mid-HOLD aborts the run with no partial output; all reset values apply.

Test Plan:
- Reset, seed_load seed_in=0, start num_vectors=1, ready=1 → valid after 5 FILL cycles. vec_data[31:0]=32'h00003039, vec_data[63:32]=32'hD3DC167E. Handshake happens, then vec_count=1, done=1, busy=0.
- No seed_load after reset, start num_vectors=201 → first vector words match a software LCG seeded with 4077570080; 201 vectors are emitted; done=1 with vec_count=201.
- ready=0 for 10 cycles in HOLD, then 1 → vec_data and vec_valid are stable across all 10 cycles; rng_state does not advance; exactly one vec_count increment.
- start num_vectors=0 → DONE next cycle; vec_valid never asserts; rng_state unchanged.
- start and seed_load pulsed during FILL → ignored; the output sequence is identical to an undisturbed run.
- rst_n dropped during the 3rd FILL cycle → all outputs return to reset values immediately; rng_state=32'hF30AC820; a new start reproduces the post-reset sequence.
